// File: rtl/psum_acc_spad.sv
// Partial-sum scratchpad with a forwarding read-modify-write accumulate pipeline,
// signed wrap/saturate arithmetic, a sticky overflow flag and a bulk-clear sweep.
module psum_acc_spad #(
  parameter int MEM_DEPTH  = 24,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_op_valid,
  input  logic                  i_op_acc,
  input  logic [ADDR_WIDTH-1:0] i_op_addr,
  input  logic [DATA_WIDTH-1:0] i_op_data,
  output logic                  o_op_ready,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_clr_start,
  output logic                  o_clr_busy,
  output logic                  o_clr_done,
  output logic                  o_ovf,
  output logic                  o_dbg_state
);

  // Handshake: an op is taken on a rising edge where i_op_valid & o_op_ready;
  // o_op_ready depends combinationally on i_clr_start so a clear always wins.

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_clr_busy;
  logic                  r_clr_done;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  r_s1_valid;
  logic                  r_s1_acc;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [DATA_WIDTH-1:0] r_s1_base;

  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic                  w_accept;
  logic                  w_op_in_range;
  logic                  w_rd_in_range;
  logic                  w_s1_in_range;
  logic [DATA_WIDTH-1:0] w_base;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_s1_ovf;
  logic [DATA_WIDTH-1:0] w_s1_result;
  logic [DATA_WIDTH-1:0] w_rd_value;

  assign o_op_ready    = (r_state == ST_IDLE) & ~i_clr_start;
  assign w_accept      = i_op_valid & o_op_ready;
  assign w_op_in_range = 32'(i_op_addr) < MEM_DEPTH;
  assign w_rd_in_range = 32'(i_rd_addr) < MEM_DEPTH;
  assign w_s1_in_range = 32'(r_s1_addr) < MEM_DEPTH;

  // Out-of-range entries behave as a constant 0 that is never written.
  always_comb begin
    w_base = '0;
    if (w_op_in_range) begin
      if (r_s1_valid && (r_s1_addr == i_op_addr)) w_base = w_s1_result;
      else                                        w_base = r_mem[i_op_addr];
    end
  end

  assign w_sum    = r_s1_base + r_s1_data;
  assign w_s1_ovf = r_s1_acc & (r_s1_base[DATA_WIDTH-1] == r_s1_data[DATA_WIDTH-1]) &
                    (w_sum[DATA_WIDTH-1] != r_s1_base[DATA_WIDTH-1]);

  always_comb begin
    w_s1_result = r_s1_data;
    if (r_s1_acc) begin
      if (w_s1_ovf && (SATURATE != 0)) w_s1_result = r_s1_base[DATA_WIDTH-1] ? SMIN : SMAX;
      else                             w_s1_result = w_sum;
    end
  end

  // Read sees every write that commits on the same edge it samples.
  always_comb begin
    w_rd_value = '0;
    if (!w_rd_in_range)                                     w_rd_value = '0;
    else if ((r_state == ST_CLEAR) && (i_rd_addr == r_ptr)) w_rd_value = '0;
    else if (r_s1_valid && (r_s1_addr == i_rd_addr))        w_rd_value = w_s1_result;
    else                                                    w_rd_value = r_mem[i_rd_addr];
  end

  // During CLEAR stage 1 is always empty, so the sweep and commit never collide.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR)                r_mem[r_ptr]     <= '0;
    else if (r_s1_valid && w_s1_in_range)   r_mem[r_s1_addr] <= w_s1_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
      r_ovf      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_acc   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
      r_s1_base  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_acc  <= i_op_acc;
        r_s1_addr <= i_op_addr;
        r_s1_data <= i_op_data;
        r_s1_base <= w_base;
      end
      if (r_s1_valid && w_s1_ovf) r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_clr_start) begin
            r_state    <= ST_CLEAR;
            r_ptr      <= '0;
            r_clr_busy <= 1'b1;
            r_ovf      <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (r_ptr == LAST_ADDR) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      r_rd_valid <= i_rd_en;
      if (i_rd_en) r_rd_data <= w_rd_value;
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_clr_busy  = r_clr_busy;
  assign o_clr_done  = r_clr_done;
  assign o_ovf       = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_psum_acc_spad.sv
// Bench for psum_acc_spad: a wrap instance and a saturate instance share stimulus;
// read expectations go into per-instance queues popped by a monitor on rd_valid.
module tb_psum_acc_spad;
  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid, op_acc, rd_en, clr_start;
  logic [AW-1:0] op_addr, rd_addr;
  logic [DW-1:0] op_data;

  logic [1:0]    op_ready_v, rd_valid_v, clr_busy_v, clr_done_v, ovf_v, state_v;
  logic [DW-1:0] rd_data0, rd_data1;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  always #5 clk = ~clk;

  psum_acc_spad #(.MEM_DEPTH(24), .DATA_WIDTH(DW), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_op_valid(op_valid), .i_op_acc(op_acc), .i_op_addr(op_addr),
    .i_op_data(op_data), .o_op_ready(op_ready_v[0]), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data0), .o_rd_valid(rd_valid_v[0]), .i_clr_start(clr_start),
    .o_clr_busy(clr_busy_v[0]), .o_clr_done(clr_done_v[0]), .o_ovf(ovf_v[0]),
    .o_dbg_state(state_v[0]));

  psum_acc_spad #(.MEM_DEPTH(24), .DATA_WIDTH(DW), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_op_valid(op_valid), .i_op_acc(op_acc), .i_op_addr(op_addr),
    .i_op_data(op_data), .o_op_ready(op_ready_v[1]), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data1), .o_rd_valid(rd_valid_v[1]), .i_clr_start(clr_start),
    .o_clr_busy(clr_busy_v[1]), .o_clr_done(clr_done_v[1]), .o_ovf(ovf_v[1]),
    .o_dbg_state(state_v[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pop and compare whenever a read result is presented.
  always @(negedge clk) begin
    if (rst_n && rd_valid_v[0]) begin
      if (exp_q0.size() == 0) check("rd_unexpected_sat0", 32'(rd_data0), 32'hdead_beef);
      else check("rd_data_sat0", 32'(rd_data0), 32'(exp_q0.pop_front()));
    end
    if (rst_n && rd_valid_v[1]) begin
      if (exp_q1.size() == 0) check("rd_unexpected_sat1", 32'(rd_data1), 32'hdead_beef);
      else check("rd_data_sat1", 32'(rd_data1), 32'(exp_q1.pop_front()));
    end
  end

  // One cycle of stimulus, starting and ending on a falling edge.
  task automatic step(input logic v, input logic acc, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic re, input logic [AW-1:0] ra,
                      input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic clr);
    op_valid = v; op_acc = acc; op_addr = a; op_data = d;
    rd_en = re; rd_addr = ra; clr_start = clr;
    if (re) begin
      exp_q0.push_back(e0);
      exp_q1.push_back(e1);
    end
    @(negedge clk);
    op_valid = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
  endtask

  task automatic op(input logic acc, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b1, acc, a, d, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    step(1'b0, 1'b0, '0, '0, 1'b1, a, e0, e1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on the falling edge right after the clr_start accept edge.
  task automatic wait_done(input string name, input logic poke);
    int   cnt;
    logic busy_ok;
    cnt = 0;
    busy_ok = 1'b1;
    while (!clr_done_v[0] && cnt < 100) begin
      if (clr_busy_v !== 2'b11) busy_ok = 1'b0;
      clr_start = poke && (cnt == 10);
      @(negedge clk);
      clr_start = 1'b0;
      cnt++;
    end
    check({name, "_cycles"}, 32'(cnt), 32'd24);
    check({name, "_busy_during"}, 32'(busy_ok), 32'd1);
    check({name, "_done_both"}, 32'(clr_done_v), 32'h3);
    check({name, "_busy_after"}, 32'(clr_busy_v), 32'h0);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(clr_done_v), 32'h0);
  endtask

  initial begin
    logic done_seen;
    rst_n = 1'b0;
    op_valid = 1'b0; op_acc = 1'b0; op_addr = '0; op_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("rst_rd_data", {rd_data1, rd_data0}, 32'h0);
    check("rst_rd_valid", 32'(rd_valid_v), 32'h0);
    check("rst_clr_busy", 32'(clr_busy_v), 32'h0);
    check("rst_clr_done", 32'(clr_done_v), 32'h0);
    check("rst_ovf", 32'(ovf_v), 32'h0);
    check("rst_op_ready", 32'(op_ready_v), 32'h3);
    check("rst_state", 32'(state_v), 32'h0);

    // Fill every entry, read back, then clear while an op contends.
    for (int i = 0; i < 24; i++) op(1'b0, AW'(i), DW'(i + 100));
    for (int i = 0; i < 24; i++) rd(AW'(i), DW'(i + 100), DW'(i + 100));
    op_valid = 1'b1; op_acc = 1'b0; op_addr = 5'd7; op_data = 16'd99; clr_start = 1'b1;
    #1;
    check("contend_op_ready", 32'(op_ready_v), 32'h0);
    @(negedge clk);
    op_valid = 1'b0; clr_start = 1'b0;
    wait_done("clear1", 1'b1);
    for (int i = 0; i < 24; i++) rd(AW'(i), '0, '0);
    check("clear1_ovf", 32'(ovf_v), 32'h0);

    // Back-to-back accumulates to one address.
    op(1'b1, 5'd5, 16'd10);
    op(1'b1, 5'd5, 16'd20);
    op(1'b1, 5'd5, 16'd30);
    op(1'b1, 5'd5, -16'sd7);
    rd(5'd5, 16'd53, 16'd53);

    // Overwrite/accumulate mix.
    op(1'b0, 5'd3, 16'd100);
    op(1'b1, 5'd3, 16'd1);
    op(1'b0, 5'd3, 16'd7);
    op(1'b1, 5'd3, 16'd2);
    rd(5'd3, 16'd9, 16'd9);

    // Read forwarding from stage 1.
    op(1'b0, 5'd2, 16'd50);
    step(1'b1, 1'b1, 5'd2, 16'd5, 1'b1, 5'd2, 16'd50, 16'd50, 1'b0);
    rd(5'd2, 16'd55, 16'd55);
    idle(1);
    rd(5'd2, 16'd55, 16'd55);

    // Out-of-range addresses and the last valid entry.
    op(1'b0, 5'd30, 16'd5);
    rd(5'd30, '0, '0);
    op(1'b1, 5'd30, 16'd9);
    rd(5'd30, '0, '0);
    op(1'b0, 5'd23, 16'hffff);
    rd(5'd23, 16'hffff, 16'hffff);
    check("ovf_before", 32'(ovf_v), 32'h0);

    // Positive overflow: wrap vs clamp.
    op(1'b0, 5'd5, 16'sd32767);
    op(1'b1, 5'd5, 16'd1);
    rd(5'd5, 16'h8000, 16'h7fff);
    check("ovf_pos", 32'(ovf_v), 32'h3);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    check("ovf_cleared", 32'(ovf_v), 32'h0);
    wait_done("clear2", 1'b0);

    // Negative overflow: wrap vs clamp.
    op(1'b0, 5'd6, 16'h8000);
    op(1'b1, 5'd6, 16'hffff);
    rd(5'd6, 16'h7fff, 16'h8000);
    check("ovf_neg", 32'(ovf_v), 32'h3);
    rd(5'd5, '0, '0);

    // Reads during the sweep, then reset part-way through it.
    op(1'b0, 5'd0, 16'd77);
    op(1'b0, 5'd10, 16'd44);
    op(1'b0, 5'd20, 16'd123);
    idle(1);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    rd(5'd0, '0, '0);
    rd(5'd10, 16'd44, 16'd44);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("midclr_rst_busy", 32'(clr_busy_v), 32'h0);
    check("midclr_rst_state", 32'(state_v), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midclr_op_ready", 32'(op_ready_v), 32'h3);
    check("midclr_busy", 32'(clr_busy_v), 32'h0);
    done_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (clr_done_v != 2'b00) done_seen = 1'b1;
    end
    check("midclr_no_done", 32'(done_seen), 32'h0);
    rd(5'd20, 16'd123, 16'd123);
    rd(5'd10, 16'd44, 16'd44);
    rd(5'd0, '0, '0);
    rd(5'd3, '0, '0);

    for (int i = 0; i < 10 && (exp_q0.size() + exp_q1.size()) != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/psum_acc_spad.md
Name: psum_acc_spad

Overview:
Next-generation partial-sum scratchpad for the PE datapath. It adds an in-place read-modify-write accumulate path, so the MAC does not round-trip psums through its own registers. Accumulation is signed, with selectable wrap or saturate, and a sticky overflow flag. The block also has a hardware bulk-clear sequencer and a forwarding registered read port. It sits between the PE MAC adder and the psum output/forwarding logic.

Parameters:
- MEM_DEPTH, 24, number of psum entries.
- DATA_WIDTH, 16, psum width, signed two's complement.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width.
- SATURATE, 0, 0 = wrap on overflow, 1 = clamp to signed max/min.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  write/accumulate request.
- op_acc  in  1  1 = accumulate (mem[addr] += op_data), 0 = overwrite (mem[addr] = op_data).
- op_addr  in  ADDR_WIDTH  target entry.
- op_data  in  DATA_WIDTH  operand.
- op_ready  out  1  request accepted when op_valid & op_ready at a clock edge.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read entry.
- rd_data  out  DATA_WIDTH  read result.
- rd_valid  out  1  rd_data valid; asserts one cycle after rd_en.
- clr_start  in  1  begin bulk clear of all entries.
- clr_busy  out  1  high while the clear sweep runs.
- clr_done  out  1  one-cycle pulse when the last entry has been cleared.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (async assert): FSM=IDLE, stage-1 valid=0, rd_data=0, rd_valid=0, clr_busy=0, clr_done=0, ovf=0, op_ready=1 after deassert. Memory array is not reset; contents are undefined until written or cleared.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_start (sweep pointer=0).
  - CLEAR writes 0 to mem[ptr] each cycle and increments ptr.
  - At ptr==MEM_DEPTH-1 the FSM writes that entry, pulses clr_done in the same cycle, and returns to IDLE.
  - clr_start while in CLEAR is ignored.
- op_ready = (state==IDLE) & ~clr_start, combinational. clr_start wins over a simultaneous op_valid; that op is not accepted.
- Two-stage RMW pipeline:
  - At accept edge E0, stage 1 captures addr, data, mode and base.
  - base = stage-1 result if stage 1 is valid and holds the same addr, else mem[op_addr]. This forwarding makes back-to-back accumulates to one address correct.
  - Stage-1 result = data (overwrite) or base+data (accumulate). It is written to mem at E1.
  - Throughput: one op per cycle, no bubbles.
- Clear versus pending op: an op accepted at E-1 commits at E0 (the clr_start edge). The sweep writes start at E1, so there is no conflict.
- Arithmetic: signed DATA_WIDTH add; overflow = operands share a sign and the sum sign differs.
  - SATURATE=0: store the wrapped sum.
  - SATURATE=1: store 0111..1 or 1000..0.
  - Either mode: set ovf at E1. ovf stays set until reset or an accepted clr_start.
- Read: at the rd_en edge, rd_data is loaded with, in priority order:
  1. 0 if in CLEAR and rd_addr==ptr;
  2. the stage-1 result if stage 1 is valid and its addr == rd_addr;
  3. otherwise mem[rd_addr].
  - rd_data therefore reflects every write committing at that same edge. Latency is 1 cycle.
  - rd_valid is rd_en registered. rd_data holds its value when rd_en=0.
- Out-of-range address (≥ MEM_DEPTH): the write is dropped, the read returns 0, and an accumulate uses base=0 with no write.
- Reset mid-operation (including mid-CLEAR): the FSM returns to IDLE, the pending stage-1 write is discarded, and a partially cleared array is left as is.

Test Plan:
- Clear then read: pulse clr_start, wait for clr_done (exactly 24 cycles after the accept edge, clr_busy high throughout) -> read all 24 entries returns 0, ovf=0.
- Back-to-back accumulate: after clear, 4 consecutive cycles of op_acc=1, addr 5, data 10,20,30,-7 -> read addr 5 one cycle after the last accept returns 53. No lost updates.
- Overwrite/accumulate mix: write addr 3 = 100, then acc addr 3 +1, then write addr 3 = 7, then acc addr 3 +2 on consecutive cycles -> final 9.
- Overflow, SATURATE=0: write 32767, acc +1 -> read -32768, ovf=1.
- Overflow, SATURATE=1: write -32768, acc -1 -> read -32768, ovf=1. A later clr_start clears ovf.
- Contention and reset:
  - clr_start with op_valid in the same cycle -> op not accepted (op_ready=0).
  - rd_en on addr 2 while an acc to addr 2 is in stage 1 -> forwarded new value.
  - rst_n low mid-CLEAR -> clr_busy=0 and op_ready=1 immediately after release, clr_done never pulses.
